// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM states, S-box tables, GF(2^8) helpers and key-length mapping.
// Pure combinational helpers; no state, latency or flow control.
package aes_pkg;

    typedef enum logic [2:0] {KCLR, KEXP, IDLE, ROUND, DONE} fsm_t;

    localparam logic [2047:0] SBOX_T = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [2047:0] INV_SBOX_T = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

    localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    // MixColumns circulant coefficients, first row, MS nibble first
    localparam logic [15:0] MIX_FWD = 16'h2311;
    localparam logic [15:0] MIX_INV = 16'hEBD9;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_T[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_T[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] m);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [3:0] key_nk(input logic [1:0] kl);
        case (kl)
            2'd2:    return 4'd6;
            2'd3:    return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] key_nr(input logic [1:0] kl);
        case (kl)
            2'd2:    return 4'd12;
            2'd3:    return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

endpackage

// File: rtl/aes_key_expand.sv
// Round-key store with a one-word-per-cycle FIPS-197 key schedule generator.
// Expansion takes 4*(Nr+1)-Nk cycles after start; rk is a combinational read of the store.
module aes_key_expand
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             start,
    input  logic [7:0][31:0] key,
    input  logic [1:0]       kl,
    input  logic [3:0]       rk_idx,
    output logic [127:0]     rk,
    output logic             last,
    output logic             ready
);

    logic [31:0] w [60];
    logic [5:0]  idx;
    logic [5:0]  total;
    logic [3:0]  nk;
    logic [2:0]  pos;
    logic [3:0]  rc;
    logic        busy;
    logic [31:0] prev;
    logic [31:0] temp;
    logic [31:0] new_w;

    assign rk   = {w[{rk_idx, 2'b00}], w[{rk_idx, 2'b01}], w[{rk_idx, 2'b10}], w[{rk_idx, 2'b11}]};
    assign last = busy && (idx == total - 6'd1);

    always_comb begin
        prev = w[idx - 6'd1];
        temp = prev;
        if (pos == 3'd0)
            temp = sub_word({prev[23:0], prev[31:24]}) ^ {RCON[rc], 24'h0};
        else if (nk == 4'd8 && pos == 3'd4)
            temp = sub_word(prev);
        new_w = w[idx - {2'b00, nk}] ^ temp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 60; j++) w[j] <= '0;
            idx   <= '0;
            total <= 6'd44;
            nk    <= 4'd4;
            pos   <= '0;
            rc    <= '0;
            busy  <= 1'b0;
            ready <= 1'b0;
        end else if (clr) begin
            for (int j = 0; j < 60; j++) w[j] <= '0;
            busy  <= 1'b0;
            ready <= 1'b0;
        end else if (start) begin
            // All eight key words are loaded; for shorter keys the excess is overwritten by the schedule
            for (int j = 0; j < 8; j++) w[j] <= key[j];
            idx   <= {2'b00, key_nk(kl)};
            nk    <= key_nk(kl);
            total <= {key_nr(kl) + 4'd1, 2'b00};
            pos   <= '0;
            rc    <= '0;
            busy  <= 1'b1;
            ready <= 1'b0;
        end else if (busy) begin
            w[idx] <= new_w;
            idx    <= idx + 6'd1;
            pos    <= ({1'b0, pos} == nk - 4'd1) ? 3'd0 : pos + 3'd1;
            if (pos == 3'd0) rc <= rc + 4'd1;
            if (last) begin
                busy  <= 1'b0;
                ready <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cipher_unit.sv
// Iterative AES-128/192/256 encrypt/decrypt core, one round per clock.
// Capture edge to CF pulse is Nr+1 cycles; CK forces key reload and aborts any block in flight.
module cipher_unit
    import aes_pkg::*;
(
    input  logic             CLK,
    input  logic             CLR,
    input  logic             CK,
    input  logic [7:0][31:0] KEY,
    input  logic [1:0]       KL,
    input  logic             enc_dec,
    input  logic [3:0][31:0] state_i,
    output logic [3:0][31:0] state_o,
    output logic             CF
);

    fsm_t         fsm;
    logic [127:0] st;
    logic [127:0] last_blk;
    logic         last_vld;
    logic         mode;
    logic [3:0]   rnd;
    logic [3:0]   nr;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic [127:0] round_out;
    logic [127:0] mid;
    logic         kx_last;
    logic         kx_ready;
    logic         start_blk;

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++)
            o[8*k +: 8] = inv ? inv_sbox(s[8*k +: 8]) : sbox(s[8*k +: 8]);
        return o;
    endfunction

    // Byte 4c+r of the block (from the MS end) is row r of column c
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int sc;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                sc = inv ? (c + 4 - r) % 4 : (c + r) % 4;
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*sc + r) -: 8];
            end
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [15:0]  coef;
        logic [7:0]   acc;
        o    = '0;
        coef = inv ? MIX_INV : MIX_FWD;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int i = 0; i < 4; i++)
                    acc = acc ^ gf_mul(s[127 - 8*(4*c + i) -: 8], coef[15 - 4*((i - r + 4) % 4) -: 4]);
                o[127 - 8*(4*c + r) -: 8] = acc;
            end
        return o;
    endfunction

    aes_key_expand u_key (
        .clk    (CLK),
        .rst_n  (CLR),
        .clr    (CK),
        .start  (fsm == KCLR && !CK),
        .key    (KEY),
        .kl     (KL),
        .rk_idx (rk_idx),
        .rk     (rk),
        .last   (kx_last),
        .ready  (kx_ready)
    );

    assign start_blk = kx_ready && (!last_vld || state_i != last_blk);

    always_comb begin
        rk_idx = mode ? rnd : nr - rnd;
        if (fsm == IDLE) rk_idx = enc_dec ? 4'd0 : nr;
    end

    always_comb begin
        mid       = '0;
        round_out = '0;
        if (mode) begin
            mid       = shift_rows(sub_bytes(st, 1'b0), 1'b0);
            round_out = ((rnd == nr) ? mid : mix_cols(mid, 1'b0)) ^ rk;
        end else begin
            mid       = sub_bytes(shift_rows(st, 1'b1), 1'b1) ^ rk;
            round_out = (rnd == nr) ? mid : mix_cols(mid, 1'b1);
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            fsm      <= KCLR;
            st       <= '0;
            last_blk <= '0;
            last_vld <= 1'b0;
            mode     <= 1'b0;
            rnd      <= '0;
            nr       <= 4'd10;
            state_o  <= '0;
            CF       <= 1'b0;
        end else begin
            CF <= 1'b0;
            if (CK) begin
                // A rekey invalidates the last block so the same input is processed again
                fsm      <= KCLR;
                last_vld <= 1'b0;
                rnd      <= '0;
            end else begin
                case (fsm)
                    KCLR: begin
                        nr  <= key_nr(KL);
                        fsm <= KEXP;
                    end
                    KEXP: if (kx_last) fsm <= IDLE;
                    IDLE: if (start_blk) begin
                        // last_blk is safe to update now: it is only compared in IDLE
                        st       <= state_i ^ rk;
                        mode     <= enc_dec;
                        last_blk <= state_i;
                        rnd      <= 4'd1;
                        fsm      <= ROUND;
                    end
                    ROUND: begin
                        st <= round_out;
                        if (rnd == nr) fsm <= DONE;
                        else           rnd <= rnd + 4'd1;
                    end
                    DONE: begin
                        state_o  <= st;
                        CF       <= 1'b1;
                        last_vld <= 1'b1;
                        fsm      <= IDLE;
                    end
                    default: fsm <= KCLR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cipher_unit.sv
// Directed-vector bench for cipher_unit using FIPS-197 and "Kung Fu" reference vectors.
module tb_cipher_unit;

    localparam logic [127:0] KF_KEY  = 128'h5468617473206D79204B756E67204675;
    localparam logic [127:0] KF_PT   = 128'h54776F204F6E65204E696E652054776F;
    localparam logic [127:0] KF_CT   = 128'h29C3505F571420F6402299B31A02D73A;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [191:0] K192    = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] CT192   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [255:0] K256    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT256   = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic             CLK = 1'b0;
    logic             CLR;
    logic             CK;
    logic [7:0][31:0] KEY;
    logic [1:0]       KL;
    logic             enc_dec;
    logic [3:0][31:0] state_i;
    logic [3:0][31:0] state_o;
    logic             CF;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    cipher_unit dut (
        .CLK     (CLK),
        .CLR     (CLR),
        .CK      (CK),
        .KEY     (KEY),
        .KL      (KL),
        .enc_dec (enc_dec),
        .state_i (state_i),
        .state_o (state_o),
        .CF      (CF)
    );

    // Counts rising edges (the first one is the capture edge) until CF is seen or the limit expires
    task automatic wait_cf(input int limit, output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < limit) begin
            @(posedge CLK);
            #1;
            cyc++;
            if (CF === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic set_key(input logic [1:0] kl, input logic [255:0] k,
                           input logic [127:0] blk, input logic enc);
        @(negedge CLK);
        for (int j = 0; j < 8; j++) KEY[j] = k[255 - 32*j -: 32];
        KL      = kl;
        state_i = blk;
        enc_dec = enc;
        CK      = 1'b1;
        repeat (2) @(negedge CLK);
        CK = 1'b0;
    endtask

    task automatic test_reset;
        int cfs;
        CLR = 1'b0; CK = 1'b1; KEY = '0; KL = 2'd1; enc_dec = 1'b1; state_i = '0;
        #12;
        n_checks++;
        if (state_o !== 128'h0) begin n_fail++; $display("FAIL reset_state_o: got %h expected 0", state_o); end
        n_checks++;
        if (CF !== 1'b0) begin n_fail++; $display("FAIL reset_cf: got %b expected 0", CF); end
        @(negedge CLK);
        CLR = 1'b1;
        cfs = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK); #1;
            if (CF === 1'b1) cfs++;
        end
        n_checks++;
        if (cfs != 0) begin n_fail++; $display("FAIL ck_held_cf: got %0d pulses expected 0", cfs); end
    endtask

    task automatic test_encrypt_128;
        int cyc; bit seen;
        set_key(2'd1, {KF_KEY, 128'h0}, KF_PT, 1'b1);
        wait_cf(300, cyc, seen);
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL enc128_cf: no CF within %0d cycles", cyc); end
        n_checks++;
        if (state_o !== KF_CT) begin n_fail++; $display("FAIL enc128_data: got %h expected %h", state_o, KF_CT); end
    endtask

    task automatic test_decrypt_128;
        int cyc; bit seen; int cfs;
        @(negedge CLK);
        state_i = KF_CT; enc_dec = 1'b0;
        wait_cf(40, cyc, seen);
        n_checks++;
        if (!seen || cyc != 12) begin n_fail++; $display("FAIL dec128_latency: got %0d edges (seen=%0b) expected 12", cyc, seen); end
        n_checks++;
        if (state_o !== KF_PT) begin n_fail++; $display("FAIL dec128_data: got %h expected %h", state_o, KF_PT); end
        cfs = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            if (CF === 1'b1) cfs++;
        end
        n_checks++;
        if (cfs != 0) begin n_fail++; $display("FAIL dec128_single_pulse: got %0d extra pulses expected 0", cfs); end
    endtask

    task automatic test_kl0;
        int cyc; bit seen;
        set_key(2'd0, {KF_KEY, 128'h0}, KF_PT, 1'b1);
        wait_cf(300, cyc, seen);
        n_checks++;
        if (!seen || state_o !== KF_CT) begin n_fail++; $display("FAIL kl0_enc: got %h (seen=%0b) expected %h", state_o, seen, KF_CT); end
    endtask

    task automatic test_192;
        int cyc; bit seen;
        set_key(2'd2, {K192, 64'h0}, FIPS_PT, 1'b1);
        wait_cf(300, cyc, seen);
        n_checks++;
        if (!seen || state_o !== CT192) begin n_fail++; $display("FAIL enc192: got %h (seen=%0b) expected %h", state_o, seen, CT192); end
        @(negedge CLK);
        state_i = CT192; enc_dec = 1'b0;
        wait_cf(40, cyc, seen);
        n_checks++;
        if (!seen || cyc != 14) begin n_fail++; $display("FAIL dec192_latency: got %0d edges (seen=%0b) expected 14", cyc, seen); end
        n_checks++;
        if (state_o !== FIPS_PT) begin n_fail++; $display("FAIL dec192_data: got %h expected %h", state_o, FIPS_PT); end
    endtask

    task automatic test_256;
        int cyc; bit seen;
        set_key(2'd3, K256, FIPS_PT, 1'b1);
        wait_cf(300, cyc, seen);
        n_checks++;
        if (!seen || state_o !== CT256) begin n_fail++; $display("FAIL enc256: got %h (seen=%0b) expected %h", state_o, seen, CT256); end
        @(negedge CLK);
        state_i = CT256; enc_dec = 1'b0;
        wait_cf(40, cyc, seen);
        n_checks++;
        if (!seen || cyc != 16) begin n_fail++; $display("FAIL dec256_latency: got %0d edges (seen=%0b) expected 16", cyc, seen); end
        n_checks++;
        if (state_o !== FIPS_PT) begin n_fail++; $display("FAIL dec256_data: got %h expected %h", state_o, FIPS_PT); end
    endtask

    task automatic test_ck_abort;
        int cyc; bit seen; int cfs;
        @(negedge CLK);
        state_i = FIPS_PT; enc_dec = 1'b1;
        repeat (4) @(negedge CLK);
        CK = 1'b1;
        cfs = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            if (CF === 1'b1) cfs++;
        end
        n_checks++;
        if (cfs != 0) begin n_fail++; $display("FAIL abort_cf: got %0d pulses expected 0", cfs); end
        n_checks++;
        if (state_o !== FIPS_PT) begin n_fail++; $display("FAIL abort_hold: got %h expected %h", state_o, FIPS_PT); end
        @(negedge CLK);
        CK = 1'b0;
        wait_cf(300, cyc, seen);
        n_checks++;
        if (!seen || state_o !== CT256) begin n_fail++; $display("FAIL abort_resume: got %h (seen=%0b) expected %h", state_o, seen, CT256); end
    endtask

    task automatic test_async_clr;
        int cyc; bit seen;
        @(negedge CLK);
        state_i = CT256; enc_dec = 1'b0;
        repeat (3) @(posedge CLK);
        #3 CLR = 1'b0;
        #1;
        n_checks++;
        if (state_o !== 128'h0) begin n_fail++; $display("FAIL clr_state_o: got %h expected 0", state_o); end
        n_checks++;
        if (CF !== 1'b0) begin n_fail++; $display("FAIL clr_cf: got %b expected 0", CF); end
        @(negedge CLK);
        CLR = 1'b1;
        wait_cf(300, cyc, seen);
        n_checks++;
        if (!seen || state_o !== FIPS_PT) begin n_fail++; $display("FAIL clr_recover: got %h (seen=%0b) expected %h", state_o, seen, FIPS_PT); end
    endtask

    task automatic test_hold;
        int cyc; bit seen; int cfs;
        cfs = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge CLK); #1;
            if (CF === 1'b1) cfs++;
            if (i == 50) enc_dec = 1'b1;
        end
        n_checks++;
        if (cfs != 0) begin n_fail++; $display("FAIL hold_no_cf: got %0d pulses expected 0", cfs); end
        @(negedge CLK);
        state_i = CT256 ^ 128'h1;
        wait_cf(16, cyc, seen);
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL bitflip_cf: no CF within %0d edges, expected by 16", cyc); end
    endtask

    initial begin
        test_reset();
        test_encrypt_128();
        test_decrypt_128();
        test_kl0();
        test_192();
        test_256();
        test_ck_abort();
        test_async_clr();
        test_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cipher_unit.md
Name: cipher_unit

Overview:
Iterative AES (Rijndael, FIPS-197) core supporting encryption and decryption with 128/192/256-bit keys. The key is expanded once into an internal round-key store. Each 128-bit block is then processed at one round per clock, and completion is flagged by a one-cycle pulse. It sits behind a host/stimulus agent that supplies the key, a mode, and blocks as 4 x 32-bit words.

Parameters:
None. Nr (10/12/14) and key-schedule sizes derive from KL at run time.

Ports:
- CLK, input, 1: rising-edge clock.
- CLR, input, 1: asynchronous active-low reset.
- CK, input, 1: synchronous key clear/reload. While high, the round-key store is cleared and held. On the falling edge (CK sampled low), key expansion starts.
- KEY, input, 8x32 (KEY[7:0]): cipher key. KEY[0] is the first (most significant) key word. Only KEY[0..Nk-1] are used.
- KL, input, 2: key length. 1 = 128 bit (Nk=4, Nr=10), 2 = 192 (Nk=6, Nr=12), 3 = 256 (Nk=8, Nr=14), 0 = treated as 128.
- enc_dec, input, 1: 1 = encrypt, 0 = decrypt.
- state_i, input, 4x32 (state_i[3:0]): input block. state_i[3] is the first (most significant) word, so the block is {state_i[3],state_i[2],state_i[1],state_i[0]}.
- state_o, output, 4x32: result block, same word order.
- CF, output, 1: completion flag, a one-cycle pulse.

Behaviour:
- Reset (CLR low, async): FSM to KCLR, round-key store zeroed, last-block register zeroed with valid bit cleared, state_o = 0, CF = 0, round counter R = 0.
- FSM states: KCLR, KEXP, IDLE, ROUND, DONE.
- KCLR:
  - Held while CK = 1; CK = 1 in any state forces KCLR next cycle, aborting any block (no CF).
  - Exits to KEXP when CK = 0.
  - KL and KEY are latched on exit.
- KEXP:
  - Generates one expanded word w[i] per cycle, i = Nk..4(Nr+1)-1, using the standard RotWord/SubWord/Rcon recurrence plus the extra SubWord for Nk = 8 at i mod 8 = 4.
  - Latency: 44/52/60 minus Nk cycles. Then go to IDLE.
- IDLE: start a block when there is no valid last block, or state_i differs from the last-processed block. On start:
  - latch state_i and enc_dec;
  - perform the initial AddRoundKey (round key 0 for encrypt, round key Nr for decrypt);
  - set R = 1 and go to ROUND.
- ROUND (one round per cycle):
  - Encrypt: SubBytes, ShiftRows, MixColumns, AddRoundKey(R). MixColumns is skipped when R = Nr.
  - Decrypt: InvShiftRows, InvSubBytes, AddRoundKey(Nr-R), InvMixColumns. InvMixColumns is skipped when R = Nr.
  - After round Nr, go to DONE.
- DONE (one cycle):
  - state_o is registered with the result and held until the next completion.
  - CF = 1 for exactly this cycle.
  - The block is recorded as last-processed (valid bit set); then go to IDLE.
- Total latency: capture edge to CF high is Nr+1 cycles.
- Inputs state_i, KEY, KL and enc_dec changing mid-block have no effect on that block.
- enc_dec changing with an unchanged state_i does not start a new block; the host must change state_i or pulse CK.
- A KL/KEY change takes effect only through a CK pulse.
- Byte order within a word follows FIPS-197 column-major mapping: word j of the block (counted from the MS word) is column j, with its MS byte in row 0.

Decomposition:
- Package aes_pkg holds:
  - FSM state enum;
  - forward and inverse S-box functions (256-entry constant tables);
  - xtime/gf_mul functions;
  - Rcon constant array;
  - the KL-to-Nk/Nr mapping function.
- One sub-module, aes_key_expand: round-key store plus the word-per-cycle generator with a ready output, indexed by the round.
- Round datapath (Sub/Shift/Mix/ARK and the inverses) is inline in cipher_unit.

Test Plan:
- KL=1, KEY = 5468617473206D79204B756E67204675 ("Thats my Kung Fu"), enc_dec=1, state_i = 54776F204F6E65204E696E652054776F -> CF pulse; state_o = 29C3505F571420F6402299B31A02D73A.
- Same key, enc_dec=0, state_i = 29C3505F571420F6402299B31A02D73A -> state_o = 54776F204F6E65204E696E652054776F. CF must pulse exactly once, Nr+1 cycles after the capture edge.
- FIPS-197 C.2: KL=2, KEY = 000102…1617, encrypt 00112233445566778899AABBCCDDEEFF -> DDA97CA4864CDFE06EAF70A0EC0D7191; decrypt back.
- FIPS-197 C.3: KL=3, KEY = 000102…1E1F, encrypt the same plaintext -> 8EA2B7CA516745BFEAFC49904B496089.
- Assert CK mid-ROUND -> no CF; state_o keeps its previous value. After CK low and re-expansion, the block completes correctly. Async CLR low mid-block -> state_o = 0 and CF = 0 immediately.
- Hold state_i constant after a completion for 100 cycles -> no further CF. Change one bit -> a new CF within Nr+2 cycles.
